// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl: syncs+debounces inc/dec/load pads (inc_raw_i,dec_raw_i,load_raw_i,duty_raw_i) into saturating duty_o with upd_o change pulse and sat_o flag
module pwm_duty_ctrl #(
  parameter int DUTY_W     = 8,
  parameter int DEB_CYCLES = 1000,
  parameter int DEB_W      = 16,
  parameter int STEP       = 1,
  parameter int DUTY_RST   = 128
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              inc_raw_i,
  input  logic              dec_raw_i,
  input  logic              load_raw_i,
  input  logic [DUTY_W-1:0] duty_raw_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic              upd_o,
  output logic              sat_o
);
  localparam int N = DUTY_W + 3;
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DUTY_W:0] STEP_W = (DUTY_W + 1)'(STEP);
  localparam logic [DUTY_W:0] MAX_W = {1'b0, {DUTY_W{1'b1}}};
  logic [N-1:0] sync1, sync2;
  logic [2:0] deb, deb_q, evt;
  logic [DUTY_W:0] inc_sum;
  logic [DUTY_W-1:0] inc_val, dec_val, duty_nxt;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {load_raw_i, dec_raw_i, inc_raw_i, duty_raw_i};
      sync2 <= sync1;
    end
  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic [DEB_W-1:0] cnt;
    logic d;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) begin
        cnt <= '0;
        d   <= 1'b0;
      end else if (sync2[DUTY_W+i] == d) cnt <= '0;
      else if (cnt == DEB_MAX) begin
        cnt <= '0;
        d   <= ~d;
      end else cnt <= cnt + 1'b1;
    assign deb[i] = d;
  end
  assign evt     = deb & ~deb_q;
  assign inc_sum = {1'b0, duty_o} + STEP_W;
  assign inc_val = inc_sum > MAX_W ? MAX_W[DUTY_W-1:0] : inc_sum[DUTY_W-1:0];
  assign dec_val = {1'b0, duty_o} < STEP_W ? '0 : duty_o - STEP_W[DUTY_W-1:0];
  assign duty_nxt = evt[2]              ? sync2[DUTY_W-1:0] :
                    evt[0] && !evt[1]   ? inc_val :
                    evt[1] && !evt[0]   ? dec_val : duty_o;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      deb_q  <= '0;
      duty_o <= DUTY_W'(DUTY_RST);
      upd_o  <= 1'b0;
    end else begin
      deb_q  <= deb;
      duty_o <= duty_nxt;
      upd_o  <= duty_nxt != duty_o;
    end
  assign sat_o = duty_o == '0 || duty_o == '1;
endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb_pwm_duty_ctrl: scoreboard bench for pwm_duty_ctrl with DEB_CYCLES=4
module tb_pwm_duty_ctrl;
  logic clk, rst, inc_raw, dec_raw, load_raw, upd, sat;
  logic [7:0] duty_raw, duty, cur;
  logic [7:0] sb[$];
  int n_tests = 0, n_fail = 0;
  pwm_duty_ctrl #(.DUTY_W(8), .DEB_CYCLES(4), .DEB_W(16), .STEP(1), .DUTY_RST(128)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .inc_raw_i(inc_raw), .dec_raw_i(dec_raw),
    .load_raw_i(load_raw), .duty_raw_i(duty_raw), .duty_o(duty), .upd_o(upd), .sat_o(sat)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (!rst && upd) begin
      if (sb.size() == 0) check("upd_spurious", 1, 0);
      else check("upd_duty", duty, sb.pop_front());
    end
  task automatic press(input logic i, input logic d, input logic l, input logic [7:0] v,
                       input int hold, input logic [7:0] exp);
    bit u;
    u = exp != cur;
    duty_raw = v;
    inc_raw = i;
    dec_raw = d;
    load_raw = l;
    if (u) sb.push_back(exp);
    repeat (6) @(posedge clk);
    #1 check("early", duty, cur);
    @(posedge clk);
    #1 check("duty_e7", duty, exp);
    check("upd_e7", upd, u);
    check("sat_e7", sat, exp == 8'h00 || exp == 8'hff);
    repeat (hold - 7) @(negedge clk);
    inc_raw = 0;
    dec_raw = 0;
    load_raw = 0;
    repeat (10) @(negedge clk);
    check("duty_hold", duty, exp);
    check("sb_empty", sb.size(), 0);
    cur = exp;
  endtask
  initial begin
    rst = 0;
    inc_raw = 0;
    dec_raw = 0;
    load_raw = 0;
    duty_raw = 0;
    #3 rst = 1;
    #1 check("rst_duty", duty, 128);
    check("rst_upd", upd, 0);
    check("rst_sat", sat, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    cur = 8'd128;
    repeat (3) @(negedge clk);
    check("post_rst_duty", duty, 128);
    press(1, 0, 0, 8'h00, 20, 8'd129);
    press(1, 0, 0, 8'h00, 20, 8'd130);
    inc_raw = 1;
    repeat (3) @(negedge clk);
    inc_raw = 0;
    @(negedge clk);
    inc_raw = 1;
    repeat (3) @(negedge clk);
    inc_raw = 0;
    repeat (15) @(negedge clk);
    check("glitch_duty", duty, 130);
    press(0, 0, 1, 8'hfe, 12, 8'hfe);
    check("sat_fe", sat, 0);
    press(1, 0, 0, 8'hfe, 12, 8'hff);
    check("sat_ff", sat, 1);
    press(1, 0, 0, 8'hfe, 12, 8'hff);
    press(0, 0, 1, 8'h00, 12, 8'h00);
    press(0, 1, 0, 8'h00, 12, 8'h00);
    check("sat_00", sat, 1);
    press(0, 0, 1, 8'h20, 12, 8'h20);
    press(1, 1, 0, 8'h20, 12, 8'h20);
    press(1, 0, 1, 8'h40, 12, 8'h40);
    press(0, 0, 1, 8'h40, 12, 8'h40);
    inc_raw = 1;
    repeat (5) @(posedge clk);
    #3 rst = 1;
    inc_raw = 0;
    #1 check("mid_rst_duty", duty, 128);
    check("mid_rst_upd", upd, 0);
    check("mid_rst_sat", sat, 0);
    @(negedge clk);
    rst = 0;
    cur = 8'd128;
    repeat (15) @(negedge clk);
    check("mid_rst_hold", duty, 128);
    check("mid_rst_sb", sb.size(), 0);
    press(0, 1, 0, 8'h00, 12, 8'd127);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
